// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus bundle: imem, predictor, redirect and ID handshake
interface fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic [63:0] predicted_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, fetch_valid, fetch_pc, fetch_instr,
           id_valid, id_pc, id_instr,
    input  imem_rdata, predicted_pc, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, fetch_valid, fetch_pc, fetch_instr,
           id_valid, id_pc, id_instr,
    output imem_rdata, predicted_pc, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with predictor hookup, redirect flush and ID queue
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  logic [63:0] pc_r;
  logic [63:0] resp_pc;
  logic        resp_valid;
  logic [CW-1:0] count;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [63:0] q_pc    [DEPTH];
  logic [31:0] q_instr [DEPTH];

  logic [63:0]   next_addr;
  logic [CW-1:0] credit;
  logic          pop;
  logic          push;

  assign bus.id_valid    = ~rst & (count != '0);
  assign bus.id_pc       = q_pc[head];
  assign bus.id_instr    = q_instr[head];
  assign bus.fetch_valid = ~rst & push;
  assign bus.fetch_pc    = resp_pc;
  assign bus.fetch_instr = bus.imem_rdata;
  assign bus.imem_addr   = next_addr;

  // Credit counts queued entries plus the response still in flight, so a
  // request is only issued when its response is guaranteed a slot.
  always_comb begin
    pop       = bus.id_valid & bus.id_ready;
    push      = resp_valid & ~bus.redirect;
    next_addr = bus.redirect ? bus.redirect_pc : (resp_valid ? bus.predicted_pc : pc_r);
    credit    = count + CW'(resp_valid) - CW'(pop);
    bus.imem_req = ~rst & (bus.redirect | (credit < CW'(DEPTH)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      resp_pc    <= RESET_PC;
      resp_valid <= 1'b0;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      pc_r       <= next_addr;
      resp_pc    <= next_addr;
      resp_valid <= bus.imem_req;
      if (bus.redirect) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[tail]    <= resp_pc;
      q_instr[tail] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a program-trace model
module tb_fetch_unit;
  localparam logic [63:0] RPC   = 64'h1000;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] seed;
  bit          br_en  = 1'b0;
  bit          rnd_br = 1'b0;
  logic [63:0] exp_pc;
  int          outst;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ seed;
  endfunction

  function automatic logic [63:0] pred_of(input logic [63:0] pc, input logic [31:0] ins);
    if (br_en && pc == 64'h1004) return 64'h2000;
    if (rnd_br && ins[2:0] == 3'b000) return pc + 64'd4 + {52'b0, ins[11:4], 4'b0};
    return pc + 64'd4;
  endfunction

  // The architectural program trace: each PC is followed by its predicted successor.
  function automatic logic [63:0] next_of(input logic [63:0] a);
    return pred_of(a, instr_of(a));
  endfunction

  always_comb bus.predicted_pc = pred_of(bus.fetch_pc, bus.fetch_instr);

  always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= instr_of(bus.imem_addr);

  task automatic cycle_in(input logic r, input logic rdy, input logic rd, input logic [63:0] rp);
    @(posedge clk);
    #1;
    rst             = r;
    bus.id_ready    = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL reset_imem_req: got %b want 0", bus.imem_req); end
    nvec++; if (bus.id_valid !== 1'b0) begin nerr++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
    nvec++; if (bus.fetch_valid !== 1'b0) begin nerr++; $display("FAIL reset_fetch_valid: got %b want 0", bus.fetch_valid); end
    cycle_in(1'b0, 1'b1, 1'b0, 64'h0);
    nvec++; if (bus.imem_req !== 1'b1) begin nerr++; $display("FAIL r_imem_req: got %b want 1", bus.imem_req); end
    nvec++; if (bus.imem_addr !== RPC) begin nerr++; $display("FAIL r_imem_addr: got %h want %h", bus.imem_addr, RPC); end
  endtask

  task automatic test_sequential();
    logic [63:0] e;
    br_en = 1'b0; rnd_br = 1'b0;
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 12; i++) begin
      cycle_in(1'b0, 1'b1, 1'b0, 64'h0);
      if (i < 2) begin
        nvec++; if (bus.id_valid !== 1'b0) begin nerr++; $display("FAIL seq_latency c%0d: id_valid %b want 0", i, bus.id_valid); end
      end else begin
        e = RPC + 64'(4 * (i - 2));
        nvec++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== instr_of(e)) begin
          nerr++;
          $display("FAIL seq c%0d: valid %b pc %h instr %h want 1 %h %h", i, bus.id_valid, bus.id_pc, bus.id_instr, e, instr_of(e));
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [63:0] exp_list [6];
    exp_list = '{64'h1000, 64'h1004, 64'h2000, 64'h2004, 64'h2008, 64'h200c};
    br_en = 1'b1; rnd_br = 1'b0;
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 8; i++) begin
      cycle_in(1'b0, 1'b1, 1'b0, 64'h0);
      if (i >= 2) begin
        nvec++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_list[i-2] || bus.id_instr !== instr_of(exp_list[i-2])) begin
          nerr++;
          $display("FAIL branch c%0d: valid %b pc %h want 1 %h", i, bus.id_valid, bus.id_pc, exp_list[i-2]);
        end
      end
    end
    br_en = 1'b0;
  endtask

  task automatic test_backpressure();
    logic rdy;
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    exp_pc = RPC; outst = 0;
    for (int i = 0; i < 30; i++) begin
      rdy = !(i >= 5 && i < 11);
      cycle_in(1'b0, rdy, 1'b0, 64'h0);
      outst = outst + int'(bus.imem_req) - int'(bus.id_valid && bus.id_ready);
      nvec++; if (outst > DEPTH) begin nerr++; $display("FAIL bp_outstanding c%0d: got %0d want <= %0d", i, outst, DEPTH); end
      if (i >= 6 && i < 11) begin
        nvec++; if (bus.imem_req !== 1'b0) begin nerr++; $display("FAIL bp_req_full c%0d: got %b want 0", i, bus.imem_req); end
      end
      if (i >= 11) begin
        nvec++; if (bus.id_valid !== 1'b1) begin nerr++; $display("FAIL bp_gap c%0d: id_valid %b want 1", i, bus.id_valid); end
      end
      if (bus.id_valid && bus.id_ready) begin
        nvec++;
        if (bus.id_pc !== exp_pc || bus.id_instr !== instr_of(exp_pc)) begin
          nerr++; $display("FAIL bp_trace c%0d: pc %h instr %h want %h %h", i, bus.id_pc, bus.id_instr, exp_pc, instr_of(exp_pc));
        end
        exp_pc = next_of(exp_pc);
      end
    end
  endtask

  task automatic test_redirect();
    logic rdy, rd;
    logic [63:0] rp;
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    exp_pc = RPC;
    for (int i = 0; i < 30; i++) begin
      rdy = !(i >= 3 && i < 8);
      rd  = (i == 8) || (i == 18);
      rp  = (i == 8) ? 64'h3000 : 64'h5000;
      cycle_in(1'b0, rdy, rd, rp);
      if (rd) begin
        nvec++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== rp || bus.fetch_valid !== 1'b0) begin
          nerr++; $display("FAIL redir_issue c%0d: req %b addr %h fv %b want 1 %h 0", i, bus.imem_req, bus.imem_addr, bus.fetch_valid, rp);
        end
      end
      if (i == 9 || i == 19) begin
        nvec++; if (bus.id_valid !== 1'b0) begin nerr++; $display("FAIL redir_flush c%0d: id_valid %b want 0", i, bus.id_valid); end
      end
      if (i == 10 || i == 20) begin
        nvec++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== ((i == 10) ? 64'h3000 : 64'h5000)) begin
          nerr++; $display("FAIL redir_first c%0d: valid %b pc %h", i, bus.id_valid, bus.id_pc);
        end
      end
      if (rd) exp_pc = rp;
      else if (bus.id_valid && bus.id_ready) begin
        nvec++;
        if (bus.id_pc !== exp_pc || bus.id_instr !== instr_of(exp_pc)) begin
          nerr++; $display("FAIL redir_trace c%0d: pc %h want %h", i, bus.id_pc, exp_pc);
        end
        exp_pc = next_of(exp_pc);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic r;
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    exp_pc = RPC;
    for (int i = 0; i < 20; i++) begin
      r = (i == 8);
      cycle_in(r, 1'b1, 1'b0, 64'h0);
      if (i == 8) begin
        nvec++;
        if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
          nerr++; $display("FAIL rstmid_outputs: valid %b req %b want 0 0", bus.id_valid, bus.imem_req);
        end
      end
      if (i == 9) begin
        nvec++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RPC || bus.id_valid !== 1'b0) begin
          nerr++; $display("FAIL rstmid_restart: req %b addr %h valid %b want 1 %h 0", bus.imem_req, bus.imem_addr, bus.id_valid, RPC);
        end
      end
      if (i == 11) begin
        nvec++; if (bus.id_valid !== 1'b1 || bus.id_pc !== RPC) begin nerr++; $display("FAIL rstmid_first: valid %b pc %h want 1 %h", bus.id_valid, bus.id_pc, RPC); end
      end
      if (r) exp_pc = RPC;
      else if (bus.id_valid && bus.id_ready) begin
        nvec++;
        if (bus.id_pc !== exp_pc || bus.id_instr !== instr_of(exp_pc)) begin
          nerr++; $display("FAIL rstmid_trace c%0d: pc %h want %h", i, bus.id_pc, exp_pc);
        end
        exp_pc = next_of(exp_pc);
      end
    end
  endtask

  task automatic test_random();
    logic rdy, rd;
    logic [63:0] rp;
    int accepted = 0;
    rnd_br = 1'b1;
    cycle_in(1'b1, 1'b1, 1'b0, 64'h0);
    exp_pc = RPC; outst = 0;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      rp  = {$urandom, $urandom};
      cycle_in(1'b0, rdy, rd, rp);
      if (bus.fetch_valid) begin
        nvec++;
        if (bus.fetch_instr !== instr_of(bus.fetch_pc)) begin
          nerr++; $display("FAIL rnd_fetch c%0d: pc %h instr %h want %h", i, bus.fetch_pc, bus.fetch_instr, instr_of(bus.fetch_pc));
        end
      end
      if (rd) begin
        outst = int'(bus.imem_req);
        nvec++; if (bus.imem_addr !== rp) begin nerr++; $display("FAIL rnd_redir c%0d: addr %h want %h", i, bus.imem_addr, rp); end
        exp_pc = rp;
      end else begin
        outst = outst + int'(bus.imem_req) - int'(bus.id_valid && bus.id_ready);
        if (bus.id_valid && bus.id_ready) begin
          accepted++;
          nvec++;
          if (bus.id_pc !== exp_pc || bus.id_instr !== instr_of(exp_pc)) begin
            nerr++; $display("FAIL rnd_trace c%0d: pc %h instr %h want %h %h", i, bus.id_pc, bus.id_instr, exp_pc, instr_of(exp_pc));
          end
          exp_pc = next_of(exp_pc);
        end
      end
      nvec++; if (outst > DEPTH) begin nerr++; $display("FAIL rnd_outstanding c%0d: got %0d want <= %0d", i, outst, DEPTH); end
    end
    nvec++; if (accepted < 100) begin nerr++; $display("FAIL rnd_progress: got %0d want >= 100", accepted); end
    rnd_br = 1'b0;
  endtask

  initial begin
    seed            = $urandom;
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 64'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_backpressure();
    test_redirect();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
